// File: rtl/control_unit.sv
// control_unit: multi-cycle RV64-style control FSM with a memory wait timeout.
// Build option CONTROL_UNIT_ILLEGAL_TRAP_EN traps unlisted opcodes into HALT; otherwise they execute as NOP.
module control_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       WE_RF,
  output logic       load_pc,
  output logic       load_ir,
  output logic       addr_sel,
  output logic       ULA_din2_sel,
  output logic       pc_next_sel,
  output logic       pc_adder_sel,
  output logic [1:0] RF_din_sel,
  output logic [2:0] state,
  output logic       illegal,
  output logic       bus_error
);
  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXECUTE = 3'd2, MEM = 3'd3, HALT = 3'd4, ERROR = 3'd5;
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  logic [2:0] cur, nxt;
  logic [7:0] wait_cnt;
  logic is_r, is_i, is_auipc, is_br, is_jal, is_jalr, is_load, is_store, is_valid;
  logic req, timeout, on;
  assign is_r     = opcode == 7'b0110011 || opcode == 7'b0111011;
  assign is_i     = opcode == 7'b0010011 || opcode == 7'b0011011 || opcode == 7'b0110111;
  assign is_auipc = opcode == 7'b0010111;
  assign is_br    = opcode == 7'b1100011;
  assign is_jal   = opcode == 7'b1101111;
  assign is_jalr  = opcode == 7'b1100111;
  assign is_load  = opcode == 7'b0000011;
  assign is_store = opcode == 7'b0100011;
  assign is_valid = is_r || is_i || is_auipc || is_br || is_jal || is_jalr || is_load || is_store;
  assign req      = cur == FETCH || cur == MEM;
  // The access that would push the count to TIMEOUT is the one that gives up; ready still wins.
  assign timeout  = req && !mem_ready && wait_cnt == 8'(TIMEOUT - 1);
  assign on       = !reset;
  assign state    = cur;
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      cur      <= FETCH;
      wait_cnt <= '0;
    end else begin
      cur      <= nxt;
      wait_cnt <= (nxt != cur) ? '0 : (req && !mem_ready) ? wait_cnt + 8'd1 : wait_cnt;
    end
  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:   nxt = mem_ready ? DECODE : timeout ? ERROR : FETCH;
      DECODE:  nxt = (is_load || is_store) ? MEM : is_valid ? EXECUTE : TRAP_EN ? HALT : EXECUTE;
      EXECUTE: nxt = FETCH;
      MEM:     nxt = mem_ready ? FETCH : timeout ? ERROR : MEM;
      HALT:    nxt = HALT;
      ERROR:   nxt = ERROR;
      default: nxt = FETCH;
    endcase
  end
  // Strobes are gated by reset so nothing leaks out while it is held.
  always_comb begin
    mem_req      = on && req;
    mem_we       = on && cur == MEM && is_store;
    addr_sel     = on && cur == FETCH;
    load_ir      = on && cur == FETCH && mem_ready;
    load_pc      = on && (cur == EXECUTE || (cur == MEM && mem_ready));
    WE_RF        = on && ((cur == EXECUTE && (is_r || is_i || is_auipc || is_jal || is_jalr))
                       || (cur == MEM && mem_ready && is_load));
    ULA_din2_sel = on && ((cur == EXECUTE && (is_i || is_jalr)) || cur == MEM);
    pc_next_sel  = on && cur == EXECUTE && (is_br || is_jal || is_jalr);
    pc_adder_sel = on && cur == EXECUTE && is_jalr;
    RF_din_sel   = !(on && cur == EXECUTE) ? 2'b00 : is_auipc ? 2'b11 : (is_jal || is_jalr) ? 2'b10
                 : (is_r || is_i) ? 2'b01 : 2'b00;
    illegal      = TRAP_EN && on && cur == HALT;
    bus_error    = on && cur == ERROR;
  end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: TIMEOUT, 16, memory-wait cycles (1..255) before bus error.
REQ-002 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: opcode  input  7  instruction[6:0] from datapath IR.
REQ-005 Port: mem_ready  input  1  memory completes current request this cycle.
REQ-006 Port: mem_req  output  1  memory access request.
REQ-007 Port: mem_we  output  1  request is a write (store); valid only with mem_req.
REQ-008 Port: WE_RF, load_pc, load_ir, addr_sel, ULA_din2_sel, pc_next_sel, pc_adder_sel  output  1 each  datapath strobes/selects.
REQ-009 Port: RF_din_sel  output  2  00 memory data, 01 ALU, 10 PC+4, 11 PC+imm.
REQ-010 Port: state  output  3  current state encoding (debug).
REQ-011 Port: illegal, bus_error  output  1 each  sticky fault flags.

Function
REQ-012 States SHALL be FETCH=0, DECODE=1, EXECUTE=2, MEM=3, HALT=4, ERROR=5; codes 6-7 SHALL return to FETCH next cycle.
REQ-013 Outputs SHALL decode from state, opcode, mem_ready only; any strobe not listed for a state SHALL be 0.
REQ-014 FETCH: mem_req=1, mem_we=0, addr_sel=1; on mem_ready, load_ir=1 same cycle, next DECODE; else remain.
REQ-015 DECODE: no strobes, one cycle; LOAD(0000011)/STORE(0100011) -> MEM; valid other opcode -> EXECUTE; illegal -> see REQ-027.
REQ-016 EXECUTE, OP/OP-32 (0110011/0111011): WE_RF=1, RF_din_sel=01, ULA_din2_sel=0, load_pc=1, pc_next_sel=0.
REQ-017 EXECUTE, OP-IMM/OP-IMM-32/LUI (0010011/0011011/0110111): as REQ-016 but ULA_din2_sel=1.
REQ-018 EXECUTE, AUIPC (0010111): WE_RF=1, RF_din_sel=11, load_pc=1, pc_next_sel=0.
REQ-019 EXECUTE, BRANCH (1100011): ULA_din2_sel=0, load_pc=1, pc_next_sel=1, pc_adder_sel=0, WE_RF=0.
REQ-020 EXECUTE, JAL (1101111): WE_RF=1, RF_din_sel=10, load_pc=1, pc_next_sel=1, pc_adder_sel=0; JALR (1100111): same with pc_adder_sel=1, ULA_din2_sel=1.
REQ-021 EXECUTE SHALL always last one cycle, then FETCH.
REQ-022 MEM: mem_req=1, addr_sel=0, ULA_din2_sel=1, mem_we=1 for STORE; on mem_ready: LOAD asserts WE_RF=1, RF_din_sel=00; both assert load_pc=1, pc_next_sel=0; next FETCH.
REQ-023 Latency with zero-wait memory: ALU/branch/jump 3 cycles, load/store 3 cycles; each wait cycle adds one.
REQ-024 Wait counter SHALL increment each cycle mem_req=1 and mem_ready=0, clear on any state change; reaching TIMEOUT SHALL move to ERROR next edge.
REQ-025 mem_ready arriving in the same cycle the counter reaches TIMEOUT SHALL complete the access (ready wins).
REQ-026 ERROR: bus_error=1, all strobes 0, remain until reset; mem_ready ignored.
REQ-027 HALT: illegal=1, all strobes 0, remain until reset.
REQ-028 mem_ready outside FETCH/MEM SHALL be ignored.

Reset
REQ-029 Assertion of reset SHALL immediately (asynchronously) force state=FETCH, wait counter=0, illegal=0, bus_error=0.
REQ-030 While reset is high all outputs SHALL be 0, including mem_req (FETCH request gated by reset).
REQ-031 Reset mid-access SHALL abandon the access; first request after deassertion is a FETCH on the next rising edge.

Configuration
REQ-032 Macro CONTROL_UNIT_ILLEGAL_TRAP_EN: defined -> unlisted opcode in DECODE goes to HALT.
REQ-033 Macro undefined -> unlisted opcode goes to EXECUTE and acts as NOP: load_pc=1, pc_next_sel=0, WE_RF=0; illegal tied 0, HALT unreachable.

Verification
REQ-034 reset, opcode=0110011, mem_ready=1 constant -> states 0,1,2,0; load_ir at cycle 1, WE_RF=1/RF_din_sel=01/load_pc=1 at cycle 3.
REQ-035 LOAD with mem_ready low 3 cycles in MEM -> mem_req=1,addr_sel=0 held 4 cycles; WE_RF=1,RF_din_sel=00 only in ready cycle.
REQ-036 TIMEOUT=4, mem_ready=0 in FETCH -> ERROR after 4 wait cycles, bus_error=1 sticky; ready on 4th cycle instead -> DECODE.
REQ-037 opcode=1111111 -> with macro: HALT, illegal=1, no strobes; without: NOP, load_pc=1, WE_RF=0, back to FETCH.
REQ-038 reset pulsed asynchronously mid-MEM store -> mem_req, mem_we drop immediately; state=0; fresh FETCH after release.
